// File: rtl/pio_sequencer_if.sv
// pio_sequencer_if: bundles the per-SM push handshake and the PIO command
// port that pio_sequencer drives.
//
// Handshake: each requester i raises req[i] and holds req_data[32i+31:32i]
// stable until it sees ack[i] high in a cycle; that cycle is the transfer.
// ack is a one-cycle, one-hot pulse. A requester may re-raise req in the
// following cycle with new data. tx_full is the PIO's (one-cycle late)
// FIFO-full view.
interface pio_sequencer_if;
    logic [3:0]   req;
    logic [127:0] req_data;
    logic [3:0]   ack;
    logic [3:0]   tx_full;
    logic [3:0]   action;
    logic [4:0]   index;
    logic [1:0]   mindex;
    logic [31:0]  din;

    // Sequencer side: consumes requests, drives grants and PIO commands.
    modport master (
        input  req,
        input  req_data,
        input  tx_full,
        output ack,
        output action,
        output index,
        output mindex,
        output din
    );

    // Requester / PIO side.
    modport slave (
        output req,
        output req_data,
        output tx_full,
        input  ack,
        input  action,
        input  index,
        input  mindex,
        input  din
    );
endinterface

// File: rtl/pio_sequencer.sv
// pio_sequencer: loads program and config words into one PIO after a start
// pulse, then arbitrates TX-FIFO pushes from four requesters round-robin.
//
// Optional feature macro: PIO_SEQ_RELOAD_EN. When defined, a start pulse in
// RUN restarts the whole load (RR pointer kept). When undefined, RUN is
// terminal until reset.
//
// Load pipeline: ROM address in cycle c, ROM data in c+1, beat registered
// onto the PIO outputs for cycle c+2.
module pio_sequencer #(
    parameter int PROG_LEN = 32,
    parameter int CONF_LEN = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic [4:0]             prog_addr,
    input  logic [15:0]            prog_data,
    output logic [4:0]             conf_addr,
    input  logic [37:0]            conf_data,
    pio_sequencer_if.master        pio,
    output logic                   busy,
    output logic                   ready,
    output logic [2:0]             state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PROG  = 3'd1,
        S_CONF  = 3'd2,
        S_DRAIN = 3'd3,
        S_RUN   = 3'd4
    } state_t;

    localparam logic [4:0] PROG_LAST  = 5'(PROG_LEN - 1);
    localparam logic [4:0] CONF_LAST  = 5'(CONF_LEN - 1);
    localparam logic [4:0] DRAIN_LAST = 5'd1;

    localparam logic [3:0] ACT_NONE  = 4'd0;
    localparam logic [3:0] ACT_INSTR = 4'd1;
    localparam logic [3:0] ACT_PUSH  = 4'd4;

    state_t      state;
    state_t      state_nx;
    logic [4:0]  cnt;
    logic [4:0]  cnt_nx;

    // ROM read in flight: issued last cycle, data arriving this cycle.
    logic        rd_valid;
    logic        rd_conf;
    logic [4:0]  rd_index;

    // Arbitration.
    logic [1:0]  rr_ptr;
    logic [3:0]  blk;
    logic [3:0]  eligible;
    logic        grant_vld;
    logic [1:0]  grant_idx;
    logic [1:0]  cand;
    logic [3:0]  ack_c;
    logic        reload_req;
    logic        grant_en;

    // PIO output registers.
    logic [3:0]  action_q;
    logic [4:0]  index_q;
    logic [1:0]  mindex_q;
    logic [31:0] din_q;

`ifdef PIO_SEQ_RELOAD_EN
    assign reload_req = (state == S_RUN) && start;
`else
    assign reload_req = 1'b0;
`endif

    // A reload cycle hands the PIO port back to the loader, so no grant.
    assign grant_en = (state == S_RUN) && !reload_req;

    // State and phase counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= 5'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next-state logic; cnt is the address within PROG/CONF and the
    // cycle count within DRAIN.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_PROG;
                    cnt_nx   = 5'd0;
                end
            end
            S_PROG: begin
                if (cnt == PROG_LAST) begin
                    state_nx = S_CONF;
                    cnt_nx   = 5'd0;
                end else begin
                    cnt_nx = cnt + 5'd1;
                end
            end
            S_CONF: begin
                if (cnt == CONF_LAST) begin
                    state_nx = S_DRAIN;
                    cnt_nx   = 5'd0;
                end else begin
                    cnt_nx = cnt + 5'd1;
                end
            end
            S_DRAIN: begin
                if (cnt == DRAIN_LAST) begin
                    state_nx = S_RUN;
                    cnt_nx   = 5'd0;
                end else begin
                    cnt_nx = cnt + 5'd1;
                end
            end
            S_RUN: begin
                if (reload_req) begin
                    state_nx = S_PROG;
                    cnt_nx   = 5'd0;
                end
            end
            default: begin
                state_nx = S_IDLE;
                cnt_nx   = 5'd0;
            end
        endcase
    end

    // ROM addresses are only non-zero inside their own phase.
    assign prog_addr = (state == S_PROG) ? cnt : 5'd0;
    assign conf_addr = (state == S_CONF) ? cnt : 5'd0;

    assign busy      = (state == S_PROG) || (state == S_CONF) || (state == S_DRAIN);
    assign ready     = (state == S_RUN);
    assign state_dbg = state;

    // Track the ROM read issued this cycle so the beat can be formed when
    // the data returns.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_conf  <= 1'b0;
            rd_index <= 5'd0;
        end else begin
            rd_valid <= (state == S_PROG) || (state == S_CONF);
            rd_conf  <= (state == S_CONF);
            rd_index <= cnt;
        end
    end

    // Round-robin pick: scan from rr_ptr upwards, first eligible SM wins.
    // blk masks an SM for the cycle after its push, before tx_full can
    // reflect that push.
    always_comb begin
        eligible  = pio.req & ~pio.tx_full & ~blk;
        grant_vld = 1'b0;
        grant_idx = 2'd0;
        cand      = 2'd0;
        ack_c     = 4'd0;
        if (grant_en) begin
            for (int off = 0; off < 4; off++) begin
                cand = rr_ptr + 2'(off);
                if (!grant_vld && eligible[cand]) begin
                    grant_vld = 1'b1;
                    grant_idx = cand;
                end
            end
        end
        if (grant_vld) begin
            ack_c[grant_idx] = 1'b1;
        end
    end

    assign pio.ack = ack_c;

    // RR pointer and one-cycle post-push block; pointer survives reloads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= 2'd0;
            blk    <= 4'd0;
        end else begin
            blk <= ack_c;
            if (grant_vld) begin
                rr_ptr <= grant_idx + 2'd1;
            end
        end
    end

    // PIO command register: load beats, push beats, or an idle beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            action_q <= ACT_NONE;
            index_q  <= 5'd0;
            mindex_q <= 2'd0;
            din_q    <= 32'd0;
        end else if (rd_valid && rd_conf) begin
            // Config words pass straight through, action 0 included.
            action_q <= conf_data[35:32];
            index_q  <= 5'd0;
            mindex_q <= conf_data[37:36];
            din_q    <= conf_data[31:0];
        end else if (rd_valid) begin
            action_q <= ACT_INSTR;
            index_q  <= rd_index;
            mindex_q <= 2'd0;
            din_q    <= {16'h0000, prog_data};
        end else if (grant_vld) begin
            action_q <= ACT_PUSH;
            index_q  <= 5'd0;
            mindex_q <= grant_idx;
            din_q    <= pio.req_data[{grant_idx, 5'd0} +: 32];
        end else begin
            action_q <= ACT_NONE;
            index_q  <= 5'd0;
            mindex_q <= 2'd0;
            din_q    <= 32'd0;
        end
    end

    assign pio.action = action_q;
    assign pio.index  = index_q;
    assign pio.mindex = mindex_q;
    assign pio.din    = din_q;

endmodule

// File: tb/tb_pio_sequencer.sv
// tb_pio_sequencer: directed phases with randomized data/requests, checked
// against a cycle-level behavioural model of the load order and the
// round-robin arbiter.
module tb_pio_sequencer;

    localparam int PL = 32;
    localparam int CL = 5;
    localparam int LOAD_END = PL + CL + 2;

    localparam int MODE_SINGLE = 0;
    localparam int MODE_ALL    = 1;
    localparam int MODE_BP     = 2;
    localparam int MODE_RAND   = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        start = 1'b0;
    logic [4:0]  prog_addr;
    logic [15:0] prog_data = '0;
    logic [4:0]  conf_addr;
    logic [37:0] conf_data = '0;
    logic        busy;
    logic        ready;
    logic [2:0]  state_dbg;

    pio_sequencer_if pio_bus ();

    pio_sequencer #(
        .PROG_LEN (PL),
        .CONF_LEN (CL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .conf_addr (conf_addr),
        .conf_data (conf_data),
        .pio       (pio_bus),
        .busy      (busy),
        .ready     (ready),
        .state_dbg (state_dbg)
    );

    // ---------------- synchronous ROM models ----------------
    logic [15:0] prog_rom [32];
    logic [37:0] conf_rom [32];

    always @(posedge clk) begin
        prog_data <= prog_rom[prog_addr];
        conf_data <= conf_rom[conf_addr];
    end

    // ---------------- model / scoreboard state ----------------
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          rr = 0;
    int          last_push [4];
    logic [3:0]  req_v = '0;
    logic [31:0] req_d [4];
    logic [3:0]  tx_v = '0;
    logic [3:0]  acked_prev = '0;
    logic [31:0] seq = 32'h1000;
    logic [37:0] exp_q [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill_roms();
        for (int k = 0; k < 32; k++) begin
            prog_rom[k] = {5'(k), 11'($urandom)};
            conf_rom[k] = {2'($urandom), 4'($urandom_range(0, 15)), 5'(k), 27'($urandom)};
        end
        // Guarantee a no-op config word inside the loaded range.
        conf_rom[1][35:32] = 4'd0;
    endtask

    task automatic drive_bus();
        pio_bus.req     = req_v;
        pio_bus.tx_full = tx_v;
        for (int i = 0; i < 4; i++) begin
            pio_bus.req_data[32*i +: 32] = req_d[i];
        end
    endtask

    task automatic model_reset();
        rr = 0;
        for (int i = 0; i < 4; i++) begin
            last_push[i] = -10;
            req_d[i] = '0;
        end
        req_v = '0;
        tx_v = '0;
        acked_prev = '0;
        exp_q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_action"}, pio_bus.action, 0);
        chk({tag, "_index"}, pio_bus.index, 0);
        chk({tag, "_mindex"}, pio_bus.mindex, 0);
        chk({tag, "_din"}, pio_bus.din, 0);
        chk({tag, "_ack"}, pio_bus.ack, 0);
        chk({tag, "_prog_addr"}, prog_addr, 0);
        chk({tag, "_conf_addr"}, conf_addr, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_ready"}, ready, 0);
    endtask

    // Asynchronous reset applied mid-cycle, checked before the next edge.
    task automatic do_reset();
        #1;
        reset = 1'b1;
        #1;
        check_all_zero("reset");
        start = 1'b0;
        model_reset();
        drive_bus();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic check_beat(input string tag);
        logic [37:0] e;
        e = '0;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
        end
        chk({tag, "_action"}, pio_bus.action, e[37:34]);
        if (e[37:34] == 4'd4) begin
            chk({tag, "_mindex"}, pio_bus.mindex, e[33:32]);
            chk({tag, "_din"}, pio_bus.din, e[31:0]);
            chk({tag, "_index"}, pio_bus.index, 0);
        end
    endtask

    // Request driver: acked requests drop, then the mode decides new ones.
    task automatic update_reqs(input int mode, input int k);
        req_v = req_v & ~acked_prev;
        acked_prev = '0;
        case (mode)
            MODE_SINGLE: begin
                if (!req_v[0]) begin
                    req_v[0] = 1'b1;
                    req_d[0] = seq;
                    seq = seq + 32'd1;
                end
                tx_v = '0;
            end
            MODE_ALL: begin
                for (int i = 0; i < 4; i++) begin
                    if (!req_v[i]) begin
                        req_v[i] = 1'b1;
                        req_d[i] = $urandom;
                    end
                end
                tx_v = '0;
            end
            MODE_BP: begin
                for (int i = 0; i < 4; i += 2) begin
                    if (!req_v[i]) begin
                        req_v[i] = 1'b1;
                        req_d[i] = $urandom;
                    end
                end
                tx_v = (k < 10) ? 4'b0001 : 4'b0000;
            end
            default: begin
                for (int i = 0; i < 4; i++) begin
                    if (!req_v[i] && $urandom_range(0, 2) != 0) begin
                        req_v[i] = 1'b1;
                        req_d[i] = $urandom;
                    end
                end
                tx_v = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            end
        endcase
        drive_bus();
    endtask

    // Load: start at n=0, beats k at n=k+3, RUN at n=PL+CL+3.
    task automatic run_load(input bit from_run, input int last_n);
        int b;
        logic [37:0] cw;
        @(posedge clk);
        #1;
        cyc++;
        if (from_run) begin
            update_reqs(MODE_SINGLE, 0);
        end
        start = 1'b1;
        #1;
        chk("start_ack", pio_bus.ack, 0);
        if (from_run) begin
            check_beat("reload_start");
        end else begin
            chk("idle_action", pio_bus.action, 0);
            chk("idle_busy", busy, 0);
        end
        exp_q.delete();
        for (int n = 1; n <= last_n; n++) begin
            @(posedge clk);
            #1;
            cyc++;
            start = 1'b0;
            #1;
            b = n - 3;
            if (b >= 0 && b < PL) begin
                chk("load_prog_action", pio_bus.action, 1);
                chk("load_prog_index", pio_bus.index, b);
                chk("load_prog_mindex", pio_bus.mindex, 0);
                chk("load_prog_din", pio_bus.din, {16'h0, prog_rom[b]});
            end else if (b >= PL && b < PL + CL) begin
                cw = conf_rom[b - PL];
                chk("load_conf_action", pio_bus.action, cw[35:32]);
                chk("load_conf_index", pio_bus.index, 0);
                chk("load_conf_mindex", pio_bus.mindex, cw[37:36]);
                chk("load_conf_din", pio_bus.din, cw[31:0]);
            end else begin
                chk("load_gap_action", pio_bus.action, 0);
            end
            chk("load_prog_addr", prog_addr, (n <= PL) ? n - 1 : 0);
            chk("load_conf_addr", conf_addr, (n > PL && n <= PL + CL) ? n - 1 - PL : 0);
            chk("load_busy", busy, 1);
            chk("load_ready", ready, 0);
            chk("load_ack", pio_bus.ack, 0);
        end
        start = 1'b0;
    endtask

    // Run phase: model picks the first eligible SM from rr upwards.
    task automatic run_phase(input int mode, input int ncyc, input bit pulse_start);
        int g;
        int i;
        logic [3:0] ea;
        for (int k = 0; k < ncyc; k++) begin
            @(posedge clk);
            #1;
            cyc++;
            update_reqs(mode, k);
            start = pulse_start ? ($urandom_range(0, 3) == 0) : 1'b0;
            #1;
            g = -1;
            for (int off = 0; off < 4; off++) begin
                i = (rr + off) % 4;
                if (g < 0 && req_v[i] && !tx_v[i] && last_push[i] != cyc - 1) begin
                    g = i;
                end
            end
            ea = (g >= 0) ? 4'(1 << g) : 4'b0000;
            chk("run_ack", pio_bus.ack, ea);
            if (mode == MODE_ALL) begin
                chk("rr_throughput", pio_bus.ack != 4'b0000, 1);
            end
            check_beat("run");
            chk("run_ready", ready, 1);
            chk("run_busy", busy, 0);
            chk("run_prog_addr", prog_addr, 0);
            if (g >= 0) begin
                exp_q.push_back({4'd4, 2'(g), req_d[g]});
                last_push[g] = cyc;
                rr = (g + 1) % 4;
                acked_prev = ea;
            end else begin
                exp_q.push_back('0);
                acked_prev = '0;
            end
        end
        start = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        fill_roms();
        model_reset();
        drive_bus();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("por");
        reset = 1'b0;

        // Full load, then a single streaming requester.
        run_load(1'b0, LOAD_END);
        run_phase(MODE_SINGLE, 24, 1'b0);

        // All four requesting from reset: strict RR, one push per cycle.
        do_reset();
        run_load(1'b0, LOAD_END);
        run_phase(MODE_ALL, 24, 1'b0);

        // Back-pressure on SM0, then release.
        do_reset();
        run_load(1'b0, LOAD_END);
        run_phase(MODE_BP, 24, 1'b0);

        // Reset during PROG beat 10, then a fresh load from index 0.
        do_reset();
        run_load(1'b0, 13);
        do_reset();
        fill_roms();
        run_load(1'b0, LOAD_END);
        run_phase(MODE_RAND, 300, 1'b0);

        // Start while running.
        do_reset();
        run_load(1'b0, LOAD_END);
`ifdef PIO_SEQ_RELOAD_EN
        run_phase(MODE_SINGLE, 8, 1'b0);
        run_load(1'b1, LOAD_END);
        run_phase(MODE_SINGLE, 12, 1'b0);
`else
        run_phase(MODE_SINGLE, 30, 1'b1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pio_sequencer.md
# pio_sequencer

Host-side controller for one `pio` instance. On a start pulse it streams the instruction memory and the state-machine configuration into the PIO over the `action`/`index`/`mindex`/`din` port, then enters a run phase. In the run phase it arbitrates TX-FIFO pushes from up to four streaming requesters, one per state machine, in round-robin order. It replaces hand-written load/config/push sequencing in top-level designs.

## Interface
Parameters:
- `PROG_LEN`, 32: number of instruction words loaded, 1..32.
- `CONF_LEN`, 5: number of configuration words issued, 1..32.

Ports:
- `clk`  in  1: single clock; all logic is rising-edge.
- `reset`  in  1: asynchronous, active-high reset.
- `start`  in  1: single-cycle pulse that begins the load sequence.
- `prog_addr`  out  5: synchronous program ROM address; data is returned one cycle later.
- `prog_data`  in  16: program ROM read data.
- `conf_addr`  out  5: synchronous config ROM address; data is returned one cycle later.
- `conf_data`  in  38: config ROM read data, `{mindex[1:0], action[3:0], din[31:0]}`.
- `req`  in  4: per-SM push request; held high with `req_data` stable until acked.
- `req_data`  in  128: push data; SM *i* uses bits `[32i+31:32i]`.
- `ack`  out  4: one-hot grant pulse, asserted in the cycle the push is accepted.
- `tx_full`  in  4: PIO TX-FIFO full flags.
- `action`  out  4: PIO action code; 0 = none, 1 = instruction write, 4 = push, others come from config.
- `index`  out  5: PIO instruction index.
- `mindex`  out  2: PIO state-machine index.
- `din`  out  32: PIO data.
- `busy`  out  1: high while in the PROG or CONF phase, including the drain cycles.
- `ready`  out  1: high while in RUN.

## Operation
- States:
  - IDLE → PROG on `start`.
  - PROG → CONF after address `PROG_LEN-1` has been issued.
  - CONF → DRAIN after address `CONF_LEN-1` has been issued.
  - DRAIN (2 cycles) → RUN.
  - RUN stays in RUN.
- PROG phase:
  - `prog_addr` = k in consecutive cycles, for k = 0..`PROG_LEN-1`.
  - Beat k appears on the outputs 2 cycles later: `action`=1, `index`=k, `mindex`=0, `din`={16'h0, `prog_data`}.
- CONF phase:
  - `conf_addr` = j in consecutive cycles, starting the cycle after the last `prog_addr`.
  - Beat j appears on the outputs 2 cycles later with the fields of `conf_data`; `index`=0.
  - Config beats follow program beats with no gap, so there are `PROG_LEN+CONF_LEN` contiguous beats.
  - A config word whose action field is 0 is passed through unchanged as a no-op beat.
- RUN phase:
  - Eligible set = `req & ~tx_full & ~blk`.
  - `blk[i]` is set for exactly one cycle after a push to SM *i*. This covers the one-cycle lag of `tx_full`.
  - At most one grant per cycle, chosen round-robin: search starts at last-granted+1 mod 4. The pointer resets to 0, so SM0 has top priority after reset.
  - The grant drives `ack[i]`=1 combinationally in the same cycle.
  - On the next cycle the outputs show `action`=4, `mindex`=i, `din`=`req_data[i]`, `index`=0.
  - Outside grant beats, `action`=0.
- `start` outside IDLE is ignored (see Configuration).
- Address outputs hold 0 outside their own phase.

## Timing
- Reset: all outputs are 0 (`action`, `index`, `mindex`, `din`, `ack`, `prog_addr`, `conf_addr`, `busy`, `ready`), state is IDLE and the RR pointer is 0. Reset takes effect immediately and asynchronously, including mid-load; it never leaves a partial beat on the outputs.
- Start to first beat: if `start` is high in cycle t, then `prog_addr`=0 in t+1, beat 0 is output in t+3, and `busy`=1 from t+1.
- Last beat: the last config beat is output in cycle t+2+`PROG_LEN`+`CONF_LEN`. In the following cycle `busy`=0 and `ready`=1.
- Push latency: `ack` in cycle c means the PIO sees the push in cycle c+1. Sustained throughput is 1 push per cycle across SMs and 1 push per 2 cycles per SM.
- Simultaneous requests: all four requesting in the same cycle are granted in RR order, one per cycle.
- `tx_full` rising in the same cycle as a `req` suppresses that grant.

## Configuration
- `PIO_SEQ_RELOAD_EN` defined:
  - `start` in RUN returns the block to PROG in the next cycle and restarts the full load.
  - No `ack` is issued in that cycle or during the reload.
  - The RR pointer is preserved.
- `PIO_SEQ_RELOAD_EN` undefined: `start` is honoured only in IDLE, and RUN is terminal until `reset`.

## Test plan
- Load sequence: `PROG_LEN`=32, `CONF_LEN`=5, ROMs filled with address-tagged data, `start` at t. Expect:
  - 37 contiguous beats from t+3.
  - Beat k: `action`=1, `index`=k.
  - Beat 32+j: `conf_data[j]` fields.
  - `ready`=1 at t+40.
- Single requester: `req`=4'b0001 held, `req_data` = incrementing values, `tx_full`=0. Expect `ack[0]` every other cycle, and `action`=4, `mindex`=0 with the matching `din` one cycle after each ack.
- Round-robin: `req`=4'b1111 from reset with `tx_full`=0. Expect grants in order 0,1,2,3,0,… with one push per cycle.
- Back-pressure: `req`=4'b0101 with `tx_full`=4'b0001. Expect only SM2 to be granted; after `tx_full[0]` falls, SM0 is granted within 2 cycles.
- Reset mid-load: assert `reset` during PROG beat 10. Expect all outputs 0 at once. A subsequent `start` reloads from index 0.
- Reload (macro on): `start` in RUN while `req`=4'b0001. Expect no `ack` and a fresh beat 0 three cycles later. With the macro off, expect `ack` to continue and no reload.
